branch_control_unit: RTL and testbench
======================================

# branch_control_unit

Branch prediction and PC-redirect controller for the 5-stage RISC-V pipeline.
- **ID stage:** predicts conditional branches with a table of 2-bit saturating counters (BHT) and redirects JAL unconditionally.
- **EX stage:** resolves branches and JALR, corrects mispredictions and flushes wrong-path instructions.
- **Inputs:** consumes the sign-extended, shifted branch/jump offsets produced by the offset logic in ID and EX.
- **Statistics:** keeps branch and misprediction counters for performance debug.

## Interface
- `BHT_ENTRIES`, 64, number of 2-bit counters; power of two, ≥ 2.
- `INDEX_W`, `$clog2(BHT_ENTRIES)`, BHT index width.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc` in 32: PC of the ID instruction.
- `id_opcode` in 7: opcode of the ID instruction.
- `id_offset` in 32: branch/JAL offset of the ID instruction, already shifted.
- `id_stall` in 1: ID held this cycle (hazard unit).
- `id_pred_taken` out 1: prediction, to be carried in ID/EX.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_opcode` in 7: opcode of the EX instruction.
- `ex_funct3` in 3: funct3 of the EX instruction.
- `ex_rs1` in 32: forwarded rs1 operand.
- `ex_rs2` in 32: forwarded rs2 operand.
- `ex_offset` in 32: shifted offset of the EX instruction.
- `ex_imm` in 32: I-type immediate, used for JALR.
- `ex_pred_taken` in 1: `id_pred_taken` carried through ID/EX.
- `pc_redirect` out 1: fetch loads `pc_target` at the next edge.
- `pc_target` out 32: redirect address.
- `flush_if_id` out 1: squash IF/ID at the next edge.
- `flush_id_ex` out 1: squash ID/EX at the next edge.
- `branch_count` out 32: number of resolved conditional branches.
- `mispredict_count` out 32: number of EX redirects (branch mispredicts plus JALR).

## Operation
- **BHT indexing:** index = `pc[INDEX_W+1:2]`. Counter values: 00/01 predict not-taken, 10/11 predict taken.
- **ID prediction:**
  - Branch opcode: `id_pred_taken` = `counter[1]`.
  - JAL: `id_pred_taken` = 1.
  - Otherwise `id_pred_taken` = 0.
  - Gated by `id_valid`.
- **ID redirect:** when `id_pred_taken` && `!id_stall` && no EX redirect:
  - `pc_redirect` = 1, `pc_target` = `id_pc + id_offset`, `flush_if_id` = 1.
- **EX resolution (conditional branch, `ex_valid`):**
  - funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - funct3 010/011 resolves not-taken.
  - taken != `ex_pred_taken` → redirect:
    - target = taken ? `ex_pc + ex_offset` : `ex_pc + 4`.
    - assert `flush_if_id` and `flush_id_ex`.
- **JALR (`ex_valid`):** always redirects to `(ex_rs1 + ex_imm) & ~1`, with both flushes.
- **JAL in EX:** no action; it was already redirected in ID.
- **Priority:** an EX redirect overrides the ID redirect in the same cycle, because the ID instruction is wrong-path. `id_stall` never gates EX.
- **BHT update:** at each edge with a valid EX conditional branch, counter[`ex_pc` index] saturates +1 if taken, −1 if not taken.
- **Counters:** `branch_count` increments once per valid EX conditional branch. `mispredict_count` increments once per EX redirect. Both wrap modulo 2^32.
- **Address arithmetic:** all adds are 32-bit modulo; no overflow detection.
- **Stall policy:** EX and the BHT update are not stalled by `id_stall`. The pipeline inserts a bubble (`ex_valid` = 0) during load-use stalls.

## Timing
- **Combinational path:** `pc_redirect`, `pc_target`, both flushes and `id_pred_taken` are combinational in the same cycle as their inputs. No registered latency.
- **Redirect penalty:** ID redirect costs 1 bubble; EX redirect costs 2 bubbles.
- **BHT read:** combinational. A write at edge N is visible to ID reads from cycle N+1. On a same-cycle read/write of the same index, ID sees the old value (no bypass).
- **Reset values:**
  - All BHT counters 2'b01.
  - `branch_count` and `mispredict_count` 0.
  - Combinational outputs follow their inputs; with `*_valid` low they are 0, and `pc_target` is 0.
- **Reset mid-operation:** state clears immediately and asynchronously; no partial update is committed.

## Structure
- Shared package/include holds:
  - opcode constants (branch, jal, jalr) from the existing RISC-V instruction set include;
  - funct3 branch codes;
  - the BHT reset value 2'b01.
- One sub-module, `branch_comparator`: combinational, inputs `funct3`, `rs1`, `rs2`, output `taken`.
- BHT is a flop array inside `branch_control_unit`; no RAM macro.

## Test plan
- **Reset:** after reset, ID branch at `id_pc` 0x100 → `id_pred_taken` 0, `pc_redirect` 0; both counters read 0.
- **Training:** BEQ at 0x100, rs1 = rs2 = 5, `ex_pred_taken` 0, `ex_offset` 0x20 → `pc_redirect` 1, `pc_target` 0x120, both flushes, `mispredict_count` 1. Next ID read at 0x100 → `id_pred_taken` 1.
- **Saturation:** repeat the taken BEQ ×3 with correct prediction → no redirect, counter stays 11. Then 2 not-taken → counter 01, prediction 0.
- **JAL and JALR:** ID JAL at 0x200 with offset −8 → `pc_target` 0x1F8, `flush_if_id` only. EX JALR rs1 = 0x303, imm = 4 → `pc_target` 0x306, both flushes.
- **Priority:** same cycle, ID predicted-taken JAL and EX BLTU mispredict (rs1 = 1, rs2 = 0xFFFF_FFFF) → EX target `ex_pc + ex_offset` wins, both flushes.
- **Stall and mid-operation reset:** with `id_stall` = 1, ID JAL gives no redirect, while an EX BNE mispredict still redirects. Assert `reset` mid-cycle → counters 0 and BHT 01 immediately.

Source files
------------

// File: rtl/branch_control_unit_pkg.sv
// Shared opcode, branch funct3 and BHT constants for the branch prediction / redirect logic.
package branch_control_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] BHT_RESET_VAL = 2'b01;

endpackage

// File: rtl/branch_control_unit_comparator.sv
// Combinational branch condition evaluation for RISC-V conditional branches.
module branch_comparator
  import branch_control_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  logic signed [31:0] w_rs1_s;
  logic signed [31:0] w_rs2_s;

  assign w_rs1_s = rs1;
  assign w_rs2_s = rs2;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = (w_rs1_s < w_rs2_s);
      F3_BGE:  taken = (w_rs1_s >= w_rs2_s);
      F3_BLTU: taken = (rs1 < rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;  // 010/011 are not branch encodings
    endcase
  end

endmodule

// File: rtl/branch_control_unit.sv
// BHT-based branch prediction in ID and branch/JALR resolution with PC redirect in EX.
module branch_control_unit
  import branch_control_unit_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int INDEX_W     = $clog2(BHT_ENTRIES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [6:0]  id_opcode,
  input  logic [31:0] id_offset,
  input  logic        id_stall,
  output logic        id_pred_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_offset,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  logic [1:0]         r_bht [BHT_ENTRIES];
  logic [31:0]        r_branch_count;
  logic [31:0]        r_mispredict_count;

  logic [INDEX_W-1:0] w_id_idx;
  logic [INDEX_W-1:0] w_ex_idx;
  logic               w_id_is_br;
  logic               w_id_is_jal;
  logic               w_ex_br;
  logic               w_ex_jalr;
  logic               w_ex_taken;
  logic               w_ex_br_mispred;
  logic               w_ex_redirect;
  logic               w_id_redirect;
  logic [31:0]        w_jalr_sum;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else    return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

  branch_comparator u_cmp (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .taken  (w_ex_taken)
  );

  assign w_id_idx    = id_pc[INDEX_W+1:2];
  assign w_ex_idx    = ex_pc[INDEX_W+1:2];
  assign w_id_is_br  = (id_opcode == OPC_BRANCH);
  assign w_id_is_jal = (id_opcode == OPC_JAL);
  assign w_ex_br     = ex_valid && (ex_opcode == OPC_BRANCH);
  assign w_ex_jalr   = ex_valid && (ex_opcode == OPC_JALR);
  assign w_jalr_sum  = ex_rs1 + ex_imm;

  assign id_pred_taken   = id_valid && (w_id_is_br ? r_bht[w_id_idx][1] : w_id_is_jal);
  assign w_ex_br_mispred = w_ex_br && (w_ex_taken != ex_pred_taken);
  assign w_ex_redirect   = w_ex_br_mispred || w_ex_jalr;
  // The ID instruction is wrong-path whenever EX redirects, so EX wins
  assign w_id_redirect   = id_pred_taken && !id_stall && !w_ex_redirect;

  always_comb begin
    pc_redirect = 1'b0;
    pc_target   = 32'h0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (w_ex_redirect) begin
      pc_redirect = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if (w_ex_jalr)       pc_target = {w_jalr_sum[31:1], 1'b0};
      else if (w_ex_taken) pc_target = ex_pc + ex_offset;
      else                 pc_target = ex_pc + 32'd4;
    end else if (w_id_redirect) begin
      pc_redirect = 1'b1;
      flush_if_id = 1'b1;
      pc_target   = id_pc + id_offset;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= BHT_RESET_VAL;
      r_branch_count     <= 32'h0;
      r_mispredict_count <= 32'h0;
    end else begin
      if (w_ex_br) begin
        r_bht[w_ex_idx] <= sat_update(r_bht[w_ex_idx], w_ex_taken);
        r_branch_count  <= r_branch_count + 32'd1;
      end
      if (w_ex_redirect) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed-vector bench for branch_control_unit with immediate-assertion checks.
module tb_branch_control_unit;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [31:0] id_offset;
  logic        id_stall;
  logic        id_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_offset;
  logic [31:0] ex_imm;
  logic        ex_pred_taken;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_control_unit #(.BHT_ENTRIES(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_opcode        (id_opcode),
    .id_offset        (id_offset),
    .id_stall         (id_stall),
    .id_pred_taken    (id_pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_opcode        (ex_opcode),
    .ex_funct3        (ex_funct3),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_offset        (ex_offset),
    .ex_imm           (ex_imm),
    .ex_pred_taken    (ex_pred_taken),
    .pc_redirect      (pc_redirect),
    .pc_target        (pc_target),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Check the four combinational redirect outputs at once
  task automatic check_redir(input string tag, input logic r, input logic [31:0] t,
                             input logic f1, input logic f2);
    check({tag, ".redirect"}, {31'd0, pc_redirect}, {31'd0, r});
    check({tag, ".target"},   pc_target, t);
    check({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, f1});
    check({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, f2});
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_opcode = 0; id_offset = 0; id_stall = 0;
    ex_valid = 0; ex_pc = 0; ex_opcode = 0; ex_funct3 = 0; ex_rs1 = 0;
    ex_rs2 = 0; ex_offset = 0; ex_imm = 0; ex_pred_taken = 0;
  endtask

  task automatic id_set(input logic [31:0] pc, input logic [6:0] op, input logic [31:0] off);
    id_valid = 1; id_pc = pc; id_opcode = op; id_offset = off;
  endtask

  task automatic ex_br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] off, input logic pred);
    ex_valid = 1; ex_pc = pc; ex_opcode = BR; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    ex_offset = off; ex_pred_taken = pred;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    step();

    // Reset state
    check_redir("idle", 0, 32'h0, 0, 0);
    check("rst.branch_count", branch_count, 0);
    check("rst.mispredict_count", mispredict_count, 0);
    id_set(32'h100, BR, 32'h20);
    #1;
    check("rst.pred", {31'd0, id_pred_taken}, 0);
    check("rst.redirect", {31'd0, pc_redirect}, 0);

    // Training: taken BEQ predicted not-taken; ID still sees old counter
    ex_br(32'h100, 3'b000, 5, 5, 32'h20, 0);
    #1;
    check_redir("train", 1, 32'h120, 1, 1);
    check("train.pred_old", {31'd0, id_pred_taken}, 0);
    step();
    check("train.mispredict_count", mispredict_count, 1);
    ex_valid = 0;
    #1;
    check("train.pred_new", {31'd0, id_pred_taken}, 1);
    check_redir("train.id_redirect", 1, 32'h120, 1, 0);

    // Saturation: three correctly predicted taken BEQs
    id_valid = 0;
    for (int i = 0; i < 3; i++) begin
      ex_br(32'h100, 3'b000, 5, 5, 32'h20, 1);
      #1;
      check("sat.no_redirect", {31'd0, pc_redirect}, 0);
      step();
    end
    ex_valid = 0;
    id_set(32'h100, BR, 32'h20);
    #1;
    check("sat.pred", {31'd0, id_pred_taken}, 1);

    // Two not-taken: 11 -> 10 -> 01
    id_valid = 0;
    ex_br(32'h100, 3'b000, 5, 6, 32'h20, 1);
    #1;
    check_redir("nt1", 1, 32'h104, 1, 1);
    step();
    ex_valid = 0;
    id_set(32'h100, BR, 32'h20);
    #1;
    check("nt1.pred", {31'd0, id_pred_taken}, 1);
    id_valid = 0;
    ex_br(32'h100, 3'b000, 5, 6, 32'h20, 1);
    step();
    ex_valid = 0;
    id_set(32'h100, BR, 32'h20);
    #1;
    check("nt2.pred", {31'd0, id_pred_taken}, 0);
    check("nt2.branch_count", branch_count, 6);
    check("nt2.mispredict_count", mispredict_count, 3);

    // JAL in ID
    id_set(32'h200, JAL, 32'hFFFF_FFF8);
    #1;
    check("jal.pred", {31'd0, id_pred_taken}, 1);
    check_redir("jal", 1, 32'h1F8, 1, 0);

    // JALR in EX
    idle();
    ex_valid = 1; ex_opcode = JALR; ex_rs1 = 32'h303; ex_imm = 4; ex_pc = 32'h300;
    #1;
    check_redir("jalr", 1, 32'h306, 1, 1);
    step();
    check("jalr.mispredict_count", mispredict_count, 4);

    // JAL in EX takes no action
    idle();
    ex_valid = 1; ex_opcode = JAL; ex_pc = 32'h300; ex_offset = 32'h40;
    #1;
    check_redir("ex_jal", 0, 32'h0, 0, 0);

    // Priority: EX BLTU mispredict beats ID JAL
    idle();
    id_set(32'h200, JAL, 32'hFFFF_FFF8);
    ex_br(32'h404, 3'b110, 1, 32'hFFFF_FFFF, 32'h40, 0);
    #1;
    check("prio.pred", {31'd0, id_pred_taken}, 1);
    check_redir("prio", 1, 32'h444, 1, 1);
    step();
    check("prio.branch_count", branch_count, 7);
    check("prio.mispredict_count", mispredict_count, 5);

    // funct3 010 resolves not-taken
    idle();
    ex_br(32'h608, 3'b010, 7, 7, 32'h80, 1);
    #1;
    check_redir("f3_010", 1, 32'h60C, 1, 1);
    step();

    // BLT signed: -1 < 1 taken, predicted taken
    ex_br(32'h70C, 3'b100, 32'hFFFF_FFFF, 1, 32'h10, 1);
    #1;
    check_redir("blt", 0, 32'h0, 0, 0);
    step();
    check("blt.branch_count", branch_count, 9);
    check("blt.mispredict_count", mispredict_count, 6);

    // Stall blocks ID redirect but not EX
    idle();
    id_stall = 1;
    id_set(32'h200, JAL, 32'hFFFF_FFF8);
    #1;
    check_redir("stall", 0, 32'h0, 0, 0);
    ex_br(32'h500, 3'b001, 1, 2, 32'h10, 0);
    #1;
    check_redir("stall.ex", 1, 32'h510, 1, 1);
    step();
    check("stall.branch_count", branch_count, 10);
    check("stall.mispredict_count", mispredict_count, 7);

    // Mid-cycle asynchronous reset
    idle();
    id_set(32'h100, BR, 32'h20);
    #1;
    check("prerst.pred", {31'd0, id_pred_taken}, 1);
    #1;
    reset = 1;
    #1;
    check("midrst.branch_count", branch_count, 0);
    check("midrst.mispredict_count", mispredict_count, 0);
    check("midrst.pred", {31'd0, id_pred_taken}, 0);
    step();
    reset = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
